// File: rtl/pwsubber_pkg.sv
// Shared constants, state encoding and helpers for the password decrementer.
// The 160-bit candidate holds 20 byte lanes; lane 0 is the leftmost character
// and occupies bits [159:152], lane 19 occupies bits [7:0].
package pwsubber_pkg;

  localparam int          PW_BYTES = 20;
  localparam int          PW_WIDTH = PW_BYTES * 8;
  localparam int          LEN_W    = 5;
  localparam int          IDX_W    = 5;
  localparam logic [7:0]  CHAR_MIN = 8'h20;
  localparam logic [7:0]  CHAR_MAX = 8'h7E;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_DONE1 = 2'd2,
    S_DONE2 = 2'd3
  } state_t;

  // Result image after a borrow runs off the leftmost character: the string
  // loses one character and every surviving lane becomes the top character.
  // Lanes at or beyond the new length are cleared.
  function automatic logic [PW_WIDTH-1:0] underflow_fill(input logic [LEN_W-1:0] len);
    logic [PW_WIDTH-1:0] v;
    v = '0;
    for (int i = 0; i < PW_BYTES; i++)
      if (i + 1 < int'(len)) v[(PW_BYTES-1-i)*8 +: 8] = CHAR_MAX;
    return v;
  endfunction

endpackage

// File: rtl/pwsubber_byte_lane.sv
// pw_byte_lane: combinational byte-lane access on the packed candidate.
// Ports:
//   vec     - full candidate vector (lane 0 in the MSBs)
//   idx     - lane index to access
//   wr_byte - replacement value for the selected lane
//   rd_byte - current value of the selected lane (0 if idx is out of range)
//   vec_out - vec with the selected lane replaced by wr_byte
module pw_byte_lane
  import pwsubber_pkg::*;
#(
  parameter int NUM_BYTES = PW_BYTES
) (
  input  logic [NUM_BYTES*8-1:0] vec,
  input  logic [IDX_W-1:0]       idx,
  input  logic [7:0]             wr_byte,
  output logic [7:0]             rd_byte,
  output logic [NUM_BYTES*8-1:0] vec_out
);

  // Decoder-style mux rather than a variable part-select keeps out-of-range
  // indices harmless: nothing is read or written for them.
  always_comb begin
    rd_byte = '0;
    vec_out = vec;
    for (int i = 0; i < NUM_BYTES; i++) begin
      if (idx == IDX_W'(i)) begin
        rd_byte                          = vec[(NUM_BYTES-1-i)*8 +: 8];
        vec_out[(NUM_BYTES-1-i)*8 +: 8]  = wr_byte;
      end
    end
  end

endmodule

// File: rtl/pwsubber.sv
// pwsubber: computes the predecessor of a printable-ASCII password, the exact
// inverse of the password incrementer. One character is processed per cycle,
// walking from the rightmost valid character towards lane 0 while borrows
// propagate.
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   in_password   - 160-bit candidate, lane 0 = bits [159:152]
//   in_length     - number of valid characters counted from lane 0
//   trigger       - start request, only honoured while idle
//   out_password  - predecessor candidate (same encoding)
//   out_length    - predecessor length
//   completed     - result strobe, high for two cycles
//   busy          - high from acceptance until completed falls
//   underflow     - length shrank, or no predecessor (empty input)
//   error         - in_length exceeded the lane count
module pwsubber
  import pwsubber_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [PW_WIDTH-1:0] in_password,
  input  logic [LEN_W-1:0]    in_length,
  input  logic                trigger,
  output logic [PW_WIDTH-1:0] out_password,
  output logic [LEN_W-1:0]    out_length,
  output logic                completed,
  output logic                busy,
  output logic                underflow,
  output logic                error
);

  state_t              state;
  logic [IDX_W-1:0]    index;
  logic [7:0]          cur_byte;
  logic [7:0]          next_byte;
  logic [PW_WIDTH-1:0] lane_vec;
  logic                borrow;

  // The working copy lives in out_password itself; each SCAN cycle reads the
  // lane at index and writes its decremented value back.
  pw_byte_lane #(.NUM_BYTES(PW_BYTES)) u_lane (
    .vec     (out_password),
    .idx     (index),
    .wr_byte (next_byte),
    .rd_byte (cur_byte),
    .vec_out (lane_vec)
  );

  // Anything at or below the bottom character borrows and wraps to the top;
  // anything above the alphabet clamps to the top character without borrow.
  assign borrow    = (cur_byte <= CHAR_MIN);
  assign next_byte = (borrow || cur_byte > CHAR_MAX) ? CHAR_MAX : cur_byte - 8'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      index        <= '0;
      out_password <= '0;
      out_length   <= '0;
      completed    <= 1'b0;
      busy         <= 1'b0;
      underflow    <= 1'b0;
      error        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (trigger) begin
            out_password <= in_password;
            out_length   <= in_length;
            busy         <= 1'b1;
            underflow    <= 1'b0;
            error        <= 1'b0;
            if (in_length == '0) begin
              // Empty string has no predecessor; report immediately.
              underflow <= 1'b1;
              completed <= 1'b1;
              index     <= '0;
              state     <= S_DONE1;
            end else if (in_length > LEN_W'(PW_BYTES)) begin
              error     <= 1'b1;
              completed <= 1'b1;
              index     <= '0;
              state     <= S_DONE1;
            end else begin
              index <= IDX_W'(in_length - 1'b1);
              state <= S_SCAN;
            end
          end
        end

        S_SCAN: begin
          if (borrow && index == '0) begin
            // Borrow out of lane 0: string shortens by one character.
            out_password <= underflow_fill(out_length);
            out_length   <= out_length - 1'b1;
            underflow    <= 1'b1;
            completed    <= 1'b1;
            state        <= S_DONE1;
          end else begin
            out_password <= lane_vec;
            if (borrow) begin
              index <= index - 1'b1;
            end else begin
              completed <= 1'b1;
              state     <= S_DONE1;
            end
          end
        end

        S_DONE1: state <= S_DONE2;

        S_DONE2: begin
          completed <= 1'b0;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pwsubber.sv
// Self-checking bench for pwsubber: directed table, hand-written multi-cycle
// sequences and randomized candidates checked against a reference model.
module tb_pwsubber;

  logic         clk = 1'b0;
  logic         rst;
  logic [159:0] in_password;
  logic [4:0]   in_length;
  logic         trigger;
  logic [159:0] out_password;
  logic [4:0]   out_length;
  logic         completed, busy, underflow, error;

  int checks   = 0;
  int failures = 0;

  pwsubber dut (
    .clk          (clk),
    .rst          (rst),
    .in_password  (in_password),
    .in_length    (in_length),
    .trigger      (trigger),
    .out_password (out_password),
    .out_length   (out_length),
    .completed    (completed),
    .busy         (busy),
    .underflow    (underflow),
    .error        (error)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        nm;
    logic [159:0] pw;
    logic [4:0]   len;
    logic [159:0] epw;
    logic [4:0]   elen;
    bit           euf;
    bit           eerr;
    int           elat;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Reference: find the rightmost valid character that can be lowered without
  // a borrow; everything to its right wraps to 0x7E. Latency is the number of
  // characters visited from the right end down to that position.
  task automatic model(input logic [159:0] pw, input logic [4:0] len,
                       output logic [159:0] opw, output logic [4:0] olen,
                       output bit uf, output bit er, output int lat);
    logic [7:0] b [20];
    int j;
    for (int i = 0; i < 20; i++) b[i] = pw[159-8*i -: 8];
    olen = len; uf = 0; er = 0; lat = 0;
    if (len == 0) uf = 1;
    else if (len > 20) er = 1;
    else begin
      j = -1;
      for (int i = 0; i < int'(len); i++) if (b[i] > 8'h20) j = i;
      if (j >= 0) begin
        b[j] = (b[j] > 8'h7E) ? 8'h7E : b[j] - 8'd1;
        for (int i = j + 1; i < int'(len); i++) b[i] = 8'h7E;
        lat = int'(len) - j;
      end else begin
        uf = 1; olen = len - 5'd1; lat = int'(len);
        for (int i = 0; i < 20; i++) b[i] = (i < int'(len) - 1) ? 8'h7E : 8'h00;
      end
    end
    opw = '0;
    for (int i = 0; i < 20; i++) opw[159-8*i -: 8] = b[i];
  endtask

  // One full operation: trigger, measure latency, check result, strobe width,
  // busy, and stability after completion. poke re-asserts trigger during
  // SCAN and DONE1 to show it is ignored.
  task automatic run_op(input string nm, input logic [159:0] pw, input logic [4:0] len,
                        input logic [159:0] epw, input logic [4:0] elen,
                        input bit euf, input bit eerr, input int elat, input bit poke);
    int lat;
    bit seen;
    @(negedge clk);
    in_password = pw; in_length = len; trigger = 1'b1;
    @(posedge clk); #1;
    trigger = 1'b0;
    lat = 0; seen = completed;
    while (!seen && lat < 30) begin
      if (poke) trigger = 1'b1;
      @(posedge clk); #1;
      trigger = 1'b0;
      lat++;
      seen = completed;
    end
    if (!seen) begin
      checks++; failures++;
      $display("FAIL %s timeout waiting for completed", nm);
      return;
    end
    chk({nm, " latency"}, 160'(lat), 160'(elat));
    chk({nm, " busy"}, 160'(busy), 160'(1));
    chk({nm, " pw"}, out_password, epw);
    chk({nm, " len"}, 160'(out_length), 160'(elen));
    chk({nm, " underflow"}, 160'(underflow), 160'(euf));
    chk({nm, " error"}, 160'(error), 160'(eerr));
    if (poke) trigger = 1'b1;
    @(posedge clk); #1;
    trigger = 1'b0;
    chk({nm, " completed 2nd"}, 160'(completed), 160'(1));
    chk({nm, " busy 2nd"}, 160'(busy), 160'(1));
    @(posedge clk); #1;
    chk({nm, " completed off"}, 160'(completed), 160'(0));
    chk({nm, " busy off"}, 160'(busy), 160'(0));
    chk({nm, " pw stable"}, out_password, epw);
    chk({nm, " len stable"}, 160'(out_length), 160'(elen));
    chk({nm, " uf stable"}, 160'(underflow), 160'(euf));
  endtask

  initial begin
    logic [159:0] rpw, epw;
    logic [4:0]   rlen, elen;
    bit           euf, eerr;
    int           elat;
    logic [7:0]   rb;
    bit           saw;

    tbl[0] = '{"AB",       {8'h41, 8'h42, {18{8'h33}}}, 5'd2, {8'h41, 8'h41, {18{8'h33}}}, 5'd2, 0, 0, 1};
    tbl[1] = '{"A_sp",     {8'h41, 8'h20, {18{8'h33}}}, 5'd2, {8'h40, 8'h7E, {18{8'h33}}}, 5'd2, 0, 0, 2};
    tbl[2] = '{"sp_sp",    {8'h20, 8'h20, {18{8'h33}}}, 5'd2, {8'h7E, {19{8'h00}}},        5'd1, 1, 0, 2};
    tbl[3] = '{"len0",     {20{8'h99}},                 5'd0, {20{8'h99}},                 5'd0, 1, 0, 0};
    tbl[4] = '{"len21",    {20{8'h44}},                 5'd21, {20{8'h44}},                5'd21, 0, 1, 0};
    tbl[5] = '{"above",    {8'h41, 8'h90, {18{8'h33}}}, 5'd2, {8'h41, 8'h7E, {18{8'h33}}}, 5'd2, 0, 0, 1};
    tbl[6] = '{"len1_sp",  {8'h20, {19{8'h33}}},        5'd1, {20{8'h00}},                 5'd0, 1, 0, 1};
    tbl[7] = '{"len20_top",{20{8'h7E}},                 5'd20, {{19{8'h7E}}, 8'h7D},       5'd20, 0, 0, 1};
    tbl[8] = '{"len31",    {20{8'h21}},                 5'd31, {20{8'h21}},                5'd31, 0, 1, 0};
    tbl[9] = '{"below",    {8'h45, 8'h05, 8'h10, {17{8'h33}}}, 5'd3,
                           {8'h44, 8'h7E, 8'h7E, {17{8'h33}}}, 5'd3, 0, 0, 3};

    rst = 1'b1; trigger = 1'b0; in_password = '0; in_length = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset pw", out_password, 160'(0));
    chk("reset len", 160'(out_length), 160'(0));
    chk("reset completed", 160'(completed), 160'(0));
    chk("reset busy", 160'(busy), 160'(0));
    chk("reset uf", 160'(underflow), 160'(0));
    chk("reset err", 160'(error), 160'(0));
    rst = 1'b0;

    foreach (tbl[i])
      run_op(tbl[i].nm, tbl[i].pw, tbl[i].len, tbl[i].epw, tbl[i].elen,
             tbl[i].euf, tbl[i].eerr, tbl[i].elat, 1'b0);

    // Triggers during SCAN and DONE1 must not alter or repeat the operation.
    run_op("poke", {8'h41, 8'h20, 8'h20, {17{8'h33}}}, 5'd3,
           {8'h40, 8'h7E, 8'h7E, {17{8'h33}}}, 5'd3, 0, 0, 3, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("poke no requeue", 160'(busy), 160'(0));

    // Trigger held high through DONE2 is re-accepted at the first idle edge.
    @(negedge clk);
    in_password = {8'h41, 8'h42, {18{8'h33}}}; in_length = 5'd2; trigger = 1'b1;
    @(posedge clk); #1;                       // E0
    @(posedge clk); #1;                       // E0+1
    chk("hold completed", 160'(completed), 160'(1));
    @(posedge clk); #1;                       // E0+2
    @(posedge clk); #1;                       // E0+3 back to idle
    chk("hold busy gap", 160'(busy), 160'(0));
    @(posedge clk); #1;                       // E0+4 re-accepted
    trigger = 1'b0;
    chk("hold reaccept busy", 160'(busy), 160'(1));
    chk("hold reaccept latch", out_password, {8'h41, 8'h42, {18{8'h33}}});
    @(posedge clk); #1;                       // E0+5
    chk("hold 2nd completed", 160'(completed), 160'(1));
    chk("hold 2nd pw", out_password, {8'h41, 8'h41, {18{8'h33}}});
    repeat (3) @(posedge clk);

    // Reset in the middle of a long borrow chain aborts with no strobe.
    @(negedge clk);
    in_password = {20{8'h20}}; in_length = 5'd20; trigger = 1'b1;
    @(posedge clk); #1;                       // E0
    trigger = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;                       // E0+5
    chk("abort pw", out_password, 160'(0));
    chk("abort len", 160'(out_length), 160'(0));
    chk("abort busy", 160'(busy), 160'(0));
    chk("abort uf", 160'(underflow), 160'(0));
    rst = 1'b0;
    saw = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (completed || busy) saw = 1;
    end
    chk("abort no strobe", 160'(saw), 160'(0));

    // Reset wins over a simultaneous trigger.
    @(negedge clk);
    rst = 1'b1; trigger = 1'b1; in_password = {20{8'h55}}; in_length = 5'd4;
    @(posedge clk); #1;
    rst = 1'b0; trigger = 1'b0;
    chk("rst prio busy", 160'(busy), 160'(0));
    chk("rst prio len", 160'(out_length), 160'(0));

    // Randomized candidates, biased towards borrow-producing characters.
    for (int t = 0; t < 40; t++) begin
      rpw = '0;
      for (int i = 0; i < 20; i++) begin
        case ($urandom_range(0, 3))
          0:       rb = 8'h20;
          1:       rb = 8'h21;
          2:       rb = 8'($urandom_range(32, 126));
          default: rb = 8'($urandom);
        endcase
        rpw[159-8*i -: 8] = rb;
      end
      rlen = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(1, 20));
      model(rpw, rlen, epw, elen, euf, eerr, elat);
      run_op($sformatf("rand%0d", t), rpw, rlen, epw, elen, euf, eerr, elat, t[0]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
